// File: rtl/kpn_pkg.sv
// Shared encodings for KPN process nodes: operation select and FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package kpn_pkg;

    typedef logic [1:0] mode_t;
    typedef logic [1:0] state_t;

    // Operation select for combining nodes
    localparam mode_t MODE_SUM  = 2'b00;
    localparam mode_t MODE_MAX  = 2'b01;
    localparam mode_t MODE_MIN  = 2'b10;
    localparam mode_t MODE_PASS = 2'b11;

    // Node FSM: wait for a full token set, pop upstream, commit the result
    localparam state_t ST_WAIT   = 2'b00;
    localparam state_t ST_POP    = 2'b01;
    localparam state_t ST_COMMIT = 2'b10;

endpackage

// File: rtl/kpn_join_node_if.sv
// Handshake bundle of a join node: upstream FWFT heads plus empty/rd, downstream empty/rd.
// Latency: n/a (wiring only).
// Backpressure: KPN style, a consumer pops with rd only while the producer shows non-empty.
// slave modport = the node, master modport = its environment (upstream channels + consumer).
interface kpn_join_node_if
    import kpn_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int N_IN      = 2,
    parameter int OUT_DEPTH = 4
);
    localparam int CNT_W = $clog2(OUT_DEPTH) + 1;

    logic [N_IN*DATA_W-1:0] in_data;    // lane k at [k*DATA_W +: DATA_W]
    logic [N_IN-1:0]        in_empty;
    logic [N_IN-1:0]        in_rd;
    mode_t                  mode;
    logic                   out_rd;
    logic [DATA_W-1:0]      out_data;
    logic                   out_empty;
    logic [CNT_W-1:0]       out_count;
    logic                   sat;

    modport master (
        output in_data, in_empty, mode, out_rd,
        input  in_rd, out_data, out_empty, out_count, sat
    );

    modport slave (
        input  in_data, in_empty, mode, out_rd,
        output in_rd, out_data, out_empty, out_count, sat
    );

endinterface

// File: rtl/kpn_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; rd_data reads 0 when empty.
// Latency: a write is visible at rd_data one clock after it is accepted.
// Backpressure: writes while full and reads while empty are dropped without pointer movement.
// Ports: clk/rst, wr_en/wr_data, rd_en/rd_data, empty, full, count (0..DEPTH).
module kpn_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow;
    // count is what tells full apart from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/kpn_join_node.sv
// KPN join node: pops one token from every input channel, combines them (sum/max/min/pass), buffers results.
// Latency: 3 clocks from the fire edge to the result at the output head; one token per 3 clocks.
// Backpressure: fires only when all inputs are non-empty and the output FIFO has space; a full FIFO parks the FSM in WAIT.
// Ports: clk, rst (async, active high), bus (slave): in_data/in_empty/in_rd, mode, out_rd/out_data/out_empty/out_count, sat.
module kpn_join_node
    import kpn_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int N_IN      = 2,
    parameter int OUT_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    kpn_join_node_if.slave bus
);
    localparam int SUM_W = DATA_W + $clog2(N_IN);
    localparam logic [DATA_W-1:0] DATA_MAX = '1;

    state_t            state;
    logic [DATA_W-1:0] opnd [N_IN];
    mode_t             opnd_mode;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] result_d;
    logic [SUM_W-1:0]  sum;
    logic [DATA_W-1:0] lane_max;
    logic [DATA_W-1:0] lane_min;
    logic              sum_ovf;
    logic              sat_q;
    logic              fire;
    logic              fifo_full;
    logic              fifo_wr;

    // Fire is only looked at in WAIT, so the upstream empties that are stale
    // during our own pop cycle can never trigger a second token.
    assign fire    = (state == ST_WAIT) && (bus.in_empty == '0) && !fifo_full;
    // Decoded from state, so an asynchronous reset drops the pop strobe at once.
    assign bus.in_rd = {N_IN{state == ST_POP}};
    assign fifo_wr   = (state == ST_COMMIT);
    assign bus.sat   = sat_q;

    // Combine the latched operands; the sum is wide enough for all lanes at full scale.
    always_comb begin
        sum      = '0;
        lane_max = opnd[0];
        lane_min = opnd[0];
        result_d = opnd[0];
        for (int k = 0; k < N_IN; k++) begin
            sum = sum + SUM_W'(opnd[k]);
            if (opnd[k] > lane_max) lane_max = opnd[k];
            if (opnd[k] < lane_min) lane_min = opnd[k];
        end
        sum_ovf = (sum > SUM_W'(DATA_MAX));
        case (opnd_mode)
            MODE_SUM: result_d = sum_ovf ? DATA_MAX : sum[DATA_W-1:0];
            MODE_MAX: result_d = lane_max;
            MODE_MIN: result_d = lane_min;
            default:  result_d = opnd[0];   // pass lane 0; all lanes still popped
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_WAIT;
            opnd_mode <= MODE_SUM;
            result_q  <= '0;
            sat_q     <= 1'b0;
            for (int k = 0; k < N_IN; k++) opnd[k] <= '0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (fire) begin
                        // mode is captured with the data so later mode changes leave this token alone
                        for (int k = 0; k < N_IN; k++) opnd[k] <= bus.in_data[k*DATA_W +: DATA_W];
                        opnd_mode <= bus.mode;
                        state     <= ST_POP;
                    end
                end
                ST_POP: begin
                    result_q <= result_d;
                    if (opnd_mode == MODE_SUM && sum_ovf) sat_q <= 1'b1;
                    state <= ST_COMMIT;
                end
                ST_COMMIT: state <= ST_WAIT;
                default:   state <= ST_WAIT;
            endcase
        end
    end

    // Space was checked at fire time and reads only free entries, so COMMIT always finds room.
    kpn_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data (result_q),
        .rd_en   (bus.out_rd),
        .rd_data (bus.out_data),
        .empty   (bus.out_empty),
        .full    (fifo_full),
        .count   (bus.out_count)
    );

endmodule

// File: tb/tb_kpn_join_node.sv
// Bench for kpn_join_node: a 4-input node driven by a queue-based upstream and checked against a token-level reference,
// plus a 2-input node exercised with exact edge timing.
// Runs to its summary line without external input.
module tb_kpn_join_node;
    import kpn_pkg::*;

    localparam int DW    = 16;
    localparam int NW    = 4;
    localparam int NS    = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    kpn_join_node_if #(.DATA_W(DW), .N_IN(NW), .OUT_DEPTH(DEPTH)) bus4 ();
    kpn_join_node_if #(.DATA_W(DW), .N_IN(NS), .OUT_DEPTH(DEPTH)) bus2 ();

    kpn_join_node #(.DATA_W(DW), .N_IN(NW), .OUT_DEPTH(DEPTH)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    kpn_join_node #(.DATA_W(DW), .N_IN(NS), .OUT_DEPTH(DEPTH)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference state for the 4-input node
    logic [DW-1:0] up_q [NW][$];   // upstream channel contents, head at [0]
    logic [DW-1:0] exp_q [$];      // results expected at the output, in order
    bit            model_sat = 1'b0;
    int            n_pops    = 0;
    bit            last_pop  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_up();
        for (int k = 0; k < NW; k++) begin
            if (up_q[k].size() != 0) begin
                bus4.in_data[k*DW +: DW] = up_q[k][0];
                bus4.in_empty[k]         = 1'b0;
            end else begin
                bus4.in_data[k*DW +: DW] = '0;
                bus4.in_empty[k]         = 1'b1;
            end
        end
    endtask

    task automatic push_all(input logic [DW-1:0] v0, v1, v2, v3);
        up_q[0].push_back(v0);
        up_q[1].push_back(v1);
        up_q[2].push_back(v2);
        up_q[3].push_back(v3);
        drive_up();
    endtask

    // One clock of the 4-input environment, evaluated at the falling edge.
    // A pop strobe seen here belongs to a fire on the rising edge just passed, so
    // the heads and mode still on the bus are what the node captured.
    task automatic tick(input bit do_rd);
        logic [DW-1:0] heads [NW];
        int unsigned   s;
        logic [DW-1:0] mx;
        logic [DW-1:0] mn;
        logic [DW-1:0] r;
        @(negedge clk);
        last_pop = 1'b0;
        if (bus4.in_rd != '0) begin
            check("in_rd_all_lanes", 32'(bus4.in_rd), 32'(4'b1111));
            check("fire_needs_all_ready", 32'(bus4.in_empty), 32'd0);
            for (int k = 0; k < NW; k++) begin
                heads[k] = (up_q[k].size() != 0) ? up_q[k].pop_front() : '0;
            end
            s  = 0;
            mx = heads[0];
            mn = heads[0];
            foreach (heads[k]) begin
                s = s + heads[k];
                if (heads[k] > mx) mx = heads[k];
                if (heads[k] < mn) mn = heads[k];
            end
            case (bus4.mode)
                MODE_SUM: begin
                    if (s > 65535) begin
                        r         = 16'hFFFF;
                        model_sat = 1'b1;
                    end else begin
                        r = DW'(s);
                    end
                end
                MODE_MAX: r = mx;
                MODE_MIN: r = mn;
                default:  r = heads[0];
            endcase
            exp_q.push_back(r);
            n_pops++;
            last_pop = 1'b1;
        end
        if (do_rd && !bus4.out_empty) begin
            if (exp_q.size() == 0) check("unexpected_output", 32'd1, 32'd0);
            else                   check("out_data", 32'(bus4.out_data), 32'(exp_q.pop_front()));
        end
        if (bus4.out_empty) check("empty_data_zero", 32'(bus4.out_data), 32'd0);
        bus4.out_rd = do_rd;
        drive_up();
    endtask

    task automatic wait_pop(input string tag);
        tick(1'b0);
        for (int i = 0; i < 20 && !last_pop; i++) tick(1'b0);
        if (!last_pop) check(tag, 32'd0, 32'd1);
    endtask

    task automatic settle();
        repeat (5) tick(1'b0);
        check("settle_count", 32'(bus4.out_count), 32'(exp_q.size()));
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (exp_q.size() != 0 || !bus4.out_empty); i++) tick(1'b1);
        repeat (4) tick(1'b0);
        check("drain_count", 32'(bus4.out_count), 32'd0);
        check("drain_all_delivered", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic random_phase(input int n_tok, input int max_val, input int read_pct);
        int pushed [NW];
        int p0;
        p0 = n_pops;
        foreach (pushed[k]) pushed[k] = 0;
        for (int t = 0; t < 6000; t++) begin
            for (int k = 0; k < NW; k++) begin
                if (pushed[k] < n_tok && $urandom_range(0, 2) == 0) begin
                    up_q[k].push_back(DW'($urandom_range(0, max_val)));
                    pushed[k]++;
                end
            end
            if ($urandom_range(0, 3) == 0) bus4.mode = mode_t'($urandom_range(0, 3));
            drive_up();
            tick($urandom_range(0, 99) < read_pct);
            if (n_pops - p0 == n_tok) break;
        end
        check("rand_all_tokens", 32'(n_pops - p0), 32'(n_tok));
        drain();
        check("rand_sat", 32'(bus4.sat), 32'(model_sat));
    endtask

    task automatic dut2_token(input logic [DW-1:0] a, input logic [DW-1:0] b);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        bus2.in_data  = {b, a};
        bus2.in_empty = 2'b00;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (bus2.in_rd == 2'b11) seen = 1'b1;
        end
        if (!seen) check("n2_fire_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus2.in_empty = 2'b11;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic dut2_read();
        @(negedge clk);
        bus2.out_rd = 1'b1;
        @(negedge clk);
        bus2.out_rd = 1'b0;
    endtask

    initial begin
        int p0;
        rst           = 1'b1;
        bus4.in_data  = '0;
        bus4.in_empty = '1;
        bus4.mode     = MODE_SUM;
        bus4.out_rd   = 1'b0;
        bus2.in_data  = '0;
        bus2.in_empty = '1;
        bus2.mode     = MODE_SUM;
        bus2.out_rd   = 1'b0;

        // Reset state
        #12;
        check("rst_in_rd4", 32'(bus4.in_rd), 32'd0);
        check("rst_empty4", 32'(bus4.out_empty), 32'd1);
        check("rst_count4", 32'(bus4.out_count), 32'd0);
        check("rst_data4", 32'(bus4.out_data), 32'd0);
        check("rst_sat4", 32'(bus4.sat), 32'd0);
        check("rst_in_rd2", 32'(bus2.in_rd), 32'd0);
        check("rst_empty2", 32'(bus2.out_empty), 32'd1);
        check("rst_count2", 32'(bus2.out_count), 32'd0);
        check("rst_sat2", 32'(bus2.sat), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 2-input node, exact timing: 5 + 7
        bus2.in_data  = {16'd7, 16'd5};
        bus2.in_empty = 2'b00;
        @(posedge clk);
        #1;
        check("n2_pop_strobe", 32'(bus2.in_rd), 32'(2'b11));
        check("n2_empty_after_fire", 32'(bus2.out_empty), 32'd1);
        @(posedge clk);
        #1;
        check("n2_pop_one_cycle", 32'(bus2.in_rd), 32'd0);
        check("n2_empty_after_pop", 32'(bus2.out_empty), 32'd1);
        bus2.in_empty = 2'b11;
        @(posedge clk);
        #1;
        check("n2_empty_after_commit", 32'(bus2.out_empty), 32'd0);
        check("n2_sum", 32'(bus2.out_data), 32'd12);
        check("n2_count", 32'(bus2.out_count), 32'd1);
        check("n2_sat_clear", 32'(bus2.sat), 32'd0);

        // 2-input node: saturation and stickiness
        dut2_read();
        check("n2_read_empties", 32'(bus2.out_empty), 32'd1);
        dut2_token(16'hFFF0, 16'h0020);
        check("n2_sat_value", 32'(bus2.out_data), 32'hFFFF);
        check("n2_sat_flag", 32'(bus2.sat), 32'd1);
        dut2_read();
        dut2_token(16'd1, 16'd2);
        check("n2_after_sat_sum", 32'(bus2.out_data), 32'd3);
        check("n2_sat_sticky", 32'(bus2.sat), 32'd1);
        dut2_read();

        // 4-input node: max then min over {3, 9, 1, 9}; mode changes after the first fire
        bus4.mode = MODE_MAX;
        push_all(16'd3, 16'd9, 16'd1, 16'd9);
        push_all(16'd3, 16'd9, 16'd1, 16'd9);
        wait_pop("max_fire_timeout");
        bus4.mode = MODE_MIN;
        wait_pop("min_fire_timeout");
        settle();
        check("max_result", 32'(bus4.out_data), 32'd9);
        tick(1'b1);
        tick(1'b0);
        check("min_result", 32'(bus4.out_data), 32'd1);
        drain();

        // Channel 1 missing for 10 cycles blocks the join
        bus4.mode = MODE_SUM;
        p0 = n_pops;
        up_q[0].push_back(16'd100);
        up_q[2].push_back(16'd200);
        up_q[3].push_back(16'd300);
        drive_up();
        for (int i = 0; i < 10; i++) begin
            tick(1'b0);
            check("blocked_no_pop", 32'(bus4.in_rd), 32'd0);
        end
        check("blocked_count", 32'(bus4.out_count), 32'd0);
        up_q[1].push_back(16'd400);
        drive_up();
        repeat (12) tick(1'b0);
        check("unblocked_one_token", 32'(n_pops - p0), 32'd1);
        check("unblocked_sum", 32'(bus4.out_data), 32'd1000);
        drain();

        // Full output FIFO stalls the node; each read lets exactly one more token in
        p0 = n_pops;
        for (int i = 0; i < 6; i++) push_all(DW'(i + 1), DW'(10), DW'(20), DW'(30));
        repeat (30) tick(1'b0);
        check("full_count", 32'(bus4.out_count), 32'd4);
        check("full_pops", 32'(n_pops - p0), 32'd4);
        repeat (10) tick(1'b0);
        check("full_holds_wait", 32'(n_pops - p0), 32'd4);
        tick(1'b1);
        repeat (10) tick(1'b0);
        check("one_more_pop", 32'(n_pops - p0), 32'd5);
        check("refilled_count", 32'(bus4.out_count), 32'd4);
        tick(1'b1);
        wait_pop("last_token_timeout");
        tick(1'b1);                       // read lands on the COMMIT edge
        tick(1'b0);
        check("simul_rw_count", 32'(bus4.out_count), 32'd3);
        check("all_six_popped", 32'(n_pops - p0), 32'd6);
        drain();

        // Randomized traffic: first without any possible saturation, then full range
        random_phase(60, 16383, 40);
        check("no_false_sat", 32'(bus4.sat), 32'd0);
        random_phase(60, 65535, 60);

        // Reset while in POP
        bus4.mode = MODE_SUM;
        push_all(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        wait_pop("sat_token_timeout");
        settle();
        check("sat_before_rst", 32'(bus4.sat), 32'd1);
        push_all(16'd1, 16'd2, 16'd3, 16'd4);
        wait_pop("rst_token_timeout");
        rst = 1'b1;
        #1;
        check("rst_drops_in_rd", 32'(bus4.in_rd), 32'd0);
        check("rst_clears_count", 32'(bus4.out_count), 32'd0);
        check("rst_clears_empty", 32'(bus4.out_empty), 32'd1);
        check("rst_clears_sat", 32'(bus4.sat), 32'd0);
        exp_q.delete();
        for (int k = 0; k < NW; k++) up_q[k].delete();
        model_sat = 1'b0;
        drive_up();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push_all(16'd10, 16'd20, 16'd30, 16'd40);
        wait_pop("post_rst_timeout");
        settle();
        check("post_rst_sum", 32'(bus4.out_data), 32'd100);
        check("post_rst_count", 32'(bus4.out_count), 32'd1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/kpn_join_node.md
Name: kpn_join_node

Overview:
- Parametrised KPN process node and the successor of the fixed two-input adder process.
- Blocking-reads one token from each of N_IN upstream FIFO channels when all are non-empty.
- Combines the tokens with a runtime-selected operation (sum, max, min, pass) and buffers the results in an internal output FIFO.
- Sits between upstream fifo channels and a downstream consumer such as the LCD writer; all handshakes are KPN-style empty/rd.

Parameters:
- DATA_W, 16, token width in bits (unsigned).
- N_IN, 2, number of input channels; legal range 2..8.
- OUT_DEPTH, 4, output FIFO depth; power of two, at least 2.

Ports:
- clk  in  1  node clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  N_IN*DATA_W  concatenated first-word-fall-through heads of the upstream channels; channel k occupies bits [k*DATA_W +: DATA_W].
- in_empty  in  N_IN  per-channel empty flag from upstream.
- in_rd  out  N_IN  per-channel pop strobe; one cycle wide.
- mode  in  2  operation select: 00 sum, 01 max, 10 min, 11 pass channel 0.
- out_rd  in  1  downstream pop strobe.
- out_data  out  DATA_W  FWFT head of the output FIFO; holds 0 when empty.
- out_empty  out  1  output FIFO empty.
- out_count  out  $clog2(OUT_DEPTH)+1  output FIFO occupancy.
- sat  out  1  sticky flag, set when a sum saturates.

Behaviour:
- Reset values: in_rd=0, out_empty=1, out_count=0, out_data=0, sat=0, FSM in WAIT, operand registers 0, FIFO pointers 0.
- FSM has three states: WAIT, POP, COMMIT.
- WAIT: fire when every in_empty bit is 0 and out_count < OUT_DEPTH. On fire, latch all in_data lanes and mode into operand registers, then go to POP. Otherwise stay in WAIT.
- POP: drive in_rd = all ones for exactly this cycle. Compute the result from the latched operands. Go to COMMIT.
- COMMIT: write the result into the output FIFO, then go to WAIT.
- Throughput: one token per 3 cycles. Latency from fire edge to out_empty falling is 3 clk edges.
- Fire is never re-evaluated in POP or COMMIT, so stale empties during the upstream pop cannot double-fire.
- Sum: computed at DATA_W+$clog2(N_IN) bits. If the result exceeds 2^DATA_W-1, write 2^DATA_W-1 and set sat. sat clears only on rst.
- Max and min: unsigned comparison across all N_IN lanes.
- Pass: lane 0 is forwarded; all channels are still popped, so the node stays a balanced join.
- mode changes while in POP or COMMIT do not affect the token in flight.
- Output FIFO, out_rd while empty: ignored, no pointer change.
- Output FIFO, write and read in the same cycle: both happen and out_count is unchanged.
- Full output FIFO: the node cannot be in POP or COMMIT with a full FIFO, because fire checked space and reads only lower the count. A full FIFO holds the FSM in WAIT.
- Pointers wrap modulo OUT_DEPTH. out_count distinguishes full from empty.
- rst mid-operation: the in-flight token is discarded, in_rd drops immediately (asynchronous), and the FIFO is emptied.

Decomposition:
- Shared package kpn_pkg holds the mode encoding constants (MODE_SUM, MODE_MAX, MODE_MIN, MODE_PASS) and the FSM state encoding, reused by future process nodes.
- One sub-module, kpn_sync_fifo: parametrised width and depth, FWFT, with count output; used for the output buffer.
- The combine function stays inline in kpn_join_node.

Test Plan:
- DATA_W=16, N_IN=2, mode=00, inputs 5 and 7 present, out_rd=0 -> in_rd=11 for one cycle at the 2nd edge; out_data=12 and out_empty=0 after the 3rd edge; sat=0.
- mode=00, inputs 0xFFF0 and 0x0020 -> out_data=0xFFFF and sat=1; sat stays 1 after further non-saturating tokens.
- N_IN=4, mode=01 then mode=10 with lanes {3, 9, 1, 9} -> outputs 9 then 1, in_rd=1111 once per token.
- Channel 1 held empty for 10 cycles while channel 0 is non-empty -> in_rd stays 0000 and out_count=0; when channel 1 fills, exactly one token is produced.
- OUT_DEPTH=4, out_rd=0, 6 tokens available upstream -> out_count saturates at 4 and the FSM stays in WAIT; one out_rd pulse -> exactly one more token is accepted. Simultaneous out_rd and COMMIT -> out_count unchanged.
- Assert rst while in POP -> in_rd=0 at once, out_count=0, sat=0; after release the node fires again from WAIT with fresh data.
